// File: rtl/qea_host_ctrl_if.sv
// qea_host_ctrl_if: host-side stream bundle for qea_host_ctrl.
//   cmd : i_cmd_valid / o_cmd_ready, i_cmd_ins_num, i_cmd_qbit_num
//   ctx : i_ctx_valid / o_ctx_ready, i_ctx_data   (one context word per beat)
//   st  : i_st_valid  / o_st_ready,  i_st_data    (one state RAM word per beat)
//   rd  : o_rd_valid  / i_rd_ready,  o_rd_data, o_rd_last (result stream)
// Signal names keep the i_/o_ prefixes as seen from the controller.
// master = host/DMA side, slave = controller side.
interface qea_host_ctrl_if #(
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16
);
  logic                               i_cmd_valid;
  logic                               o_cmd_ready;
  logic [GATE_CONTEXT_ADDR_WIDTH:0]   i_cmd_ins_num;
  logic [MAX_QBIT_WIDTH-1:0]          i_cmd_qbit_num;

  logic                               i_ctx_valid;
  logic                               o_ctx_ready;
  logic [2*DATA_WIDTH-1:0]            i_ctx_data;

  logic                               i_st_valid;
  logic                               o_st_ready;
  logic [PE_NUM*2*DATA_WIDTH-1:0]     i_st_data;

  logic                               o_rd_valid;
  logic                               i_rd_ready;
  logic [PE_NUM*2*DATA_WIDTH-1:0]     o_rd_data;
  logic                               o_rd_last;

  modport master (
    output i_cmd_valid, i_cmd_ins_num, i_cmd_qbit_num,
    output i_ctx_valid, i_ctx_data,
    output i_st_valid, i_st_data,
    output i_rd_ready,
    input  o_cmd_ready, o_ctx_ready, o_st_ready,
    input  o_rd_valid, o_rd_data, o_rd_last
  );

  modport slave (
    input  i_cmd_valid, i_cmd_ins_num, i_cmd_qbit_num,
    input  i_ctx_valid, i_ctx_data,
    input  i_st_valid, i_st_data,
    input  i_rd_ready,
    output o_cmd_ready, o_ctx_ready, o_st_ready,
    output o_rd_valid, o_rd_data, o_rd_last
  );
endinterface

// File: rtl/qea_host_ctrl.sv
// qea_host_ctrl: sequences one QEA job end to end.
//   1. accept a command (context word count, qubit count)
//   2. stream context words into the QEA context RAM (addr 0..ins_num-1)
//   3. stream the initial state vector into the state RAM (addr 0..N_ST-1)
//   4. pulse o_qea_start for one cycle, count cycles until i_qea_complete
//   5. read the state RAM back word by word onto the result stream
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   host                host stream bundle (cmd / ctx / st / rd)
//   o_busy              job in progress (any state but IDLE)
//   o_done / o_err      one-cycle pulses: last result accepted / command rejected
//   o_cycles            start-to-complete cycle count of the last job
//   o_qea_*             QEA start, qubit count, context and state RAM ports
//   i_qea_complete      QEA completion flag
//   i_qea_state_dout    QEA state RAM read data (RD_LAT cycles after address)
module qea_host_ctrl #(
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int RD_LAT                  = 1,
  parameter int CYC_WIDTH               = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  qea_host_ctrl_if.slave                     host,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err,
  output logic [CYC_WIDTH-1:0]               o_cycles,
  output logic                               o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]          o_qea_qbit_num,
  output logic                               o_qea_ctx_en,
  output logic                               o_qea_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_qea_ctx_addr,
  output logic [2*DATA_WIDTH-1:0]            o_qea_ctx_data,
  output logic                               o_qea_state_ena,
  output logic                               o_qea_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_qea_state_addra,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]     o_qea_state_dina,
  input  logic                               i_qea_complete,
  input  logic [PE_NUM*2*DATA_WIDTH-1:0]     i_qea_state_dout
);
  localparam int CW = GATE_CONTEXT_ADDR_WIDTH + 1;
  localparam int SW = PE_NUM * 2 * DATA_WIDTH;
  localparam int AW = STATE_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LD_CTX, ST_LD_ST, ST_START, ST_RUN, ST_RD_ADDR, ST_RD_WAIT, ST_RD_OUT
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]             ins_q;
  logic [CW-1:0]             ctx_cnt;
  logic [MAX_QBIT_WIDTH-1:0] qbit_q;
  logic [AW-1:0]             st_last_q;   // N_ST-1 of the current job
  logic [AW-1:0]             st_cnt;      // load index, then readout index
  logic [2:0]                wait_cnt;
  logic [CYC_WIDTH-1:0]      cyc_cnt;
  logic [CYC_WIDTH-1:0]      cycles_q;
  logic [SW-1:0]             rd_data_q;
  logic                      done_q;
  logic                      err_q;

  logic [31:0] qbit_ext;
  logic        cmd_bad;
  logic [AW-1:0] cmd_st_last;
  logic cmd_fire, ctx_fire, st_fire, rd_fire;
  logic ctx_last, st_last, rd_capture;

  // Rejected: fewer than 2 qubits, or 2**(qbit-2) words exceed the state RAM.
  assign qbit_ext = 32'(host.i_cmd_qbit_num);
  assign cmd_bad  = (qbit_ext < 32'd2) || (qbit_ext > 32'(AW) + 32'd2);
  // 2**(qbit-2)-1 formed as an all-ones mask shifted right; only used when !cmd_bad.
  assign cmd_st_last = {AW{1'b1}} >> (32'(AW) + 32'd2 - qbit_ext);

  assign cmd_fire   = (state_q == ST_IDLE)   && host.i_cmd_valid;
  assign ctx_fire   = (state_q == ST_LD_CTX) && host.i_ctx_valid;
  assign st_fire    = (state_q == ST_LD_ST)  && host.i_st_valid;
  assign rd_fire    = (state_q == ST_RD_OUT) && host.i_rd_ready;
  assign ctx_last   = (ctx_cnt == ins_q - CW'(1));
  assign st_last    = (st_cnt == st_last_q);
  assign rd_capture = (state_q == ST_RD_WAIT) && (wait_cnt == 3'(RD_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Load strobes are combinational from the handshake so each word reaches
  // the RAM in the same cycle it is accepted.
  always_comb begin
    state_d             = state_q;
    host.o_cmd_ready    = 1'b0;
    host.o_ctx_ready    = 1'b0;
    host.o_st_ready     = 1'b0;
    host.o_rd_valid     = 1'b0;
    host.o_rd_last      = 1'b0;
    o_qea_start         = 1'b0;
    o_qea_ctx_en        = 1'b0;
    o_qea_ctx_wea       = 1'b0;
    o_qea_ctx_addr      = '0;
    o_qea_ctx_data      = '0;
    o_qea_state_ena     = 1'b0;
    o_qea_state_wea     = 1'b0;
    o_qea_state_addra   = '0;
    o_qea_state_dina    = '0;
    unique case (state_q)
      ST_IDLE: begin
        host.o_cmd_ready = 1'b1;
        if (host.i_cmd_valid && !cmd_bad)
          state_d = (host.i_cmd_ins_num == '0) ? ST_LD_ST : ST_LD_CTX;
      end
      ST_LD_CTX: begin
        host.o_ctx_ready = 1'b1;
        if (host.i_ctx_valid) begin
          o_qea_ctx_en   = 1'b1;
          o_qea_ctx_wea  = 1'b1;
          o_qea_ctx_addr = ctx_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0];
          o_qea_ctx_data = host.i_ctx_data;
          if (ctx_last) state_d = ST_LD_ST;
        end
      end
      ST_LD_ST: begin
        host.o_st_ready = 1'b1;
        if (host.i_st_valid) begin
          o_qea_state_ena   = 1'b1;
          o_qea_state_wea   = 1'b1;
          o_qea_state_addra = st_cnt;
          o_qea_state_dina  = host.i_st_data;
          if (st_last) state_d = ST_START;
        end
      end
      ST_START: begin
        o_qea_start = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (i_qea_complete) state_d = ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        o_qea_state_ena   = 1'b1;
        o_qea_state_addra = st_cnt;
        state_d           = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_capture) state_d = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        host.o_rd_valid = 1'b1;
        host.o_rd_last  = st_last;
        if (host.i_rd_ready) state_d = st_last ? ST_IDLE : ST_RD_ADDR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_q     <= '0;
      ctx_cnt   <= '0;
      qbit_q    <= '0;
      st_last_q <= '0;
      st_cnt    <= '0;
      wait_cnt  <= '0;
      cyc_cnt   <= '0;
      cycles_q  <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= rd_fire && st_last;
      err_q  <= cmd_fire && cmd_bad;

      if (cmd_fire && !cmd_bad) begin
        ins_q     <= host.i_cmd_ins_num;
        qbit_q    <= host.i_cmd_qbit_num;
        st_last_q <= cmd_st_last;
        ctx_cnt   <= '0;
        st_cnt    <= '0;
      end

      if (ctx_fire) ctx_cnt <= ctx_cnt + CW'(1);

      // st_cnt is reused as the readout index, so it wraps to 0 after loading.
      if (st_fire)             st_cnt <= st_last ? '0 : st_cnt + AW'(1);
      if (rd_fire && !st_last) st_cnt <= st_cnt + AW'(1);

      if (state_q == ST_START) begin
        cyc_cnt <= CYC_WIDTH'(1);
      end else if (state_q == ST_RUN) begin
        if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + CYC_WIDTH'(1);
        if (i_qea_complete) cycles_q <= cyc_cnt;
      end

      if (state_q == ST_RD_ADDR)      wait_cnt <= '0;
      else if (state_q == ST_RD_WAIT) wait_cnt <= wait_cnt + 3'd1;

      if (rd_capture) rd_data_q <= i_qea_state_dout;
    end
  end

  assign host.o_rd_data = rd_data_q;
  assign o_qea_qbit_num = qbit_q;
  assign o_cycles       = cycles_q;
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_qea_host_ctrl.sv
module tb_qea_host_ctrl;
  localparam int PE   = 4;
  localparam int DW   = 32;
  localparam int QW   = 6;
  localparam int SAW  = 16;
  localparam int GAW  = 16;
  localparam int CW   = GAW + 1;
  localparam int SWD  = PE * 2 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qea_host_ctrl_if #(.PE_NUM(PE), .DATA_WIDTH(DW), .MAX_QBIT_WIDTH(QW),
                     .GATE_CONTEXT_ADDR_WIDTH(GAW)) host();

  logic            busy, done, err, start, ctx_en, ctx_wea, st_ena, st_wea;
  logic [31:0]     cycles;
  logic [QW-1:0]   qbit_out;
  logic [GAW-1:0]  ctx_addr;
  logic [2*DW-1:0] ctx_data;
  logic [SAW-1:0]  st_addra;
  logic [SWD-1:0]  st_dina;
  logic            qea_complete = 1'b0;
  logic [SWD-1:0]  qea_dout = '0;

  qea_host_ctrl #(
    .PE_NUM(PE), .DATA_WIDTH(DW), .MAX_QBIT_WIDTH(QW), .STATE_ADDR_WIDTH(SAW),
    .GATE_CONTEXT_ADDR_WIDTH(GAW), .RD_LAT(1), .CYC_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host(host),
    .o_busy(busy), .o_done(done), .o_err(err), .o_cycles(cycles),
    .o_qea_start(start), .o_qea_qbit_num(qbit_out),
    .o_qea_ctx_en(ctx_en), .o_qea_ctx_wea(ctx_wea),
    .o_qea_ctx_addr(ctx_addr), .o_qea_ctx_data(ctx_data),
    .o_qea_state_ena(st_ena), .o_qea_state_wea(st_wea),
    .o_qea_state_addra(st_addra), .o_qea_state_dina(st_dina),
    .i_qea_complete(qea_complete), .i_qea_state_dout(qea_dout)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Mock QEA: state RAM with 1-cycle read, completion mock_lat cycles after
  // the start pulse (held high until the next start), and on completion every
  // stored word is inverted so the result stream must be ~initial_state.
  int              mock_lat = 10;
  int              remaining = 0;
  int              start_cnt = 0;
  int              strobe_cnt = 0;
  logic [SWD-1:0]  smem [int];
  logic [GAW-1:0]  ctx_addr_q [$];
  logic [2*DW-1:0] ctx_data_q [$];
  logic [SAW-1:0]  st_addr_q [$];

  logic [2*DW-1:0] cw_q [$];
  logic [SWD-1:0]  sw_q [$];

  always @(posedge clk) begin
    if (ctx_en && ctx_wea) begin
      ctx_addr_q.push_back(ctx_addr);
      ctx_data_q.push_back(ctx_data);
    end
    if (st_ena && st_wea) begin
      smem[int'(st_addra)] = st_dina;
      st_addr_q.push_back(st_addra);
    end
    if (st_ena && !st_wea)
      qea_dout <= smem.exists(int'(st_addra)) ? smem[int'(st_addra)] : '0;
    if (start || ctx_en || st_ena) strobe_cnt++;
    if (start) start_cnt++;
    if (!rst_n) begin
      remaining    <= 0;
      qea_complete <= 1'b0;
    end else if (start) begin
      if (mock_lat <= 1) begin
        qea_complete <= 1'b1;
        foreach (smem[i]) smem[i] = ~smem[i];
      end else begin
        qea_complete <= 1'b0;
        remaining    <= mock_lat - 1;
      end
    end else if (remaining > 0) begin
      remaining <= remaining - 1;
      if (remaining == 1) begin
        qea_complete <= 1'b1;
        foreach (smem[i]) smem[i] = ~smem[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [SWD-1:0] obs, input logic [SWD-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic prep(input int ins, input int qbit, input bit fix_amp);
    logic [SWD-1:0] w;
    cw_q.delete(); sw_q.delete();
    ctx_addr_q.delete(); ctx_data_q.delete(); st_addr_q.delete();
    for (int i = 0; i < ins; i++) cw_q.push_back({$urandom, $urandom});
    for (int i = 0; i < (1 << (qbit - 2)); i++) begin
      w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (fix_amp && i == 0) w[63:0] = 64'h40000000_00000000;
      sw_q.push_back(w);
    end
  endtask

  // All stream tasks are entered and left on a falling edge.
  task automatic send_cmd(input int ins, input int qbit);
    int g = 0;
    host.i_cmd_valid    = 1'b1;
    host.i_cmd_ins_num  = CW'(ins);
    host.i_cmd_qbit_num = QW'(qbit);
    while (!host.o_cmd_ready && g < 100) begin @(negedge clk); g++; end
    chk("cmd_ready", host.o_cmd_ready, 1);
    @(negedge clk);
    host.i_cmd_valid = 1'b0;
  endtask

  task automatic load_ctx(input string name, input bit gappy);
    int k = 0;
    int g = 0;
    while (k < cw_q.size() && g < 5000) begin
      host.i_ctx_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      host.i_ctx_data  = cw_q[k];
      if (host.i_ctx_valid && host.o_ctx_ready) k++;
      @(negedge clk); g++;
    end
    host.i_ctx_valid = 1'b0;
    chk({name, " ctx_beats"}, k, cw_q.size());
  endtask

  task automatic load_st(input string name, input bit gappy);
    int k = 0;
    int g = 0;
    while (k < sw_q.size() && g < 5000) begin
      host.i_st_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      host.i_st_data  = sw_q[k];
      if (host.i_st_valid && host.o_st_ready) k++;
      @(negedge clk); g++;
    end
    host.i_st_valid = 1'b0;
    chk({name, " st_beats"}, k, sw_q.size());
  endtask

  task automatic read_out(input string name, input bit stall);
    int j = 0;
    int g = 0;
    int stall_left = stall ? 5 : 0;
    int n = sw_q.size();
    logic [SWD-1:0] held = '0;
    bit held_v = 1'b0;
    while (j < n && g < 3000) begin
      if (host.o_rd_valid) begin
        if (held_v) chk({name, " rd_hold"}, host.o_rd_data, held);
        if (stall_left > 0) begin
          host.i_rd_ready = 1'b0;
          stall_left--;
        end else begin
          host.i_rd_ready = ($urandom_range(0, 3) != 0);
        end
        if (host.i_rd_ready) begin
          chk($sformatf("%s rd_data[%0d]", name, j), host.o_rd_data, ~sw_q[j]);
          chk($sformatf("%s rd_last[%0d]", name, j), host.o_rd_last, (j == n - 1));
          j++;
          held_v = 1'b0;
        end else begin
          held   = host.o_rd_data;
          held_v = 1'b1;
        end
      end else begin
        host.i_rd_ready = 1'($urandom_range(0, 1));
        held_v = 1'b0;
      end
      @(negedge clk); g++;
    end
    host.i_rd_ready = 1'b0;
    chk({name, " rd_words"}, j, n);
    chk({name, " done_pulse"}, done, 1);
    chk({name, " busy_end"}, busy, 0);
    @(negedge clk);
    chk({name, " done_clear"}, done, 0);
  endtask

  task automatic post_check(input string name, input int lat, input int s0);
    int nc;
    int ns;
    nc = (ctx_addr_q.size() < cw_q.size()) ? ctx_addr_q.size() : cw_q.size();
    ns = (st_addr_q.size() < sw_q.size()) ? st_addr_q.size() : sw_q.size();
    chk({name, " ctx_writes"}, ctx_addr_q.size(), cw_q.size());
    for (int k = 0; k < nc; k++) begin
      chk($sformatf("%s ctx_addr[%0d]", name, k), ctx_addr_q[k], k);
      chk($sformatf("%s ctx_data[%0d]", name, k), ctx_data_q[k], cw_q[k]);
    end
    chk({name, " st_writes"}, st_addr_q.size(), sw_q.size());
    for (int k = 0; k < ns; k++)
      chk($sformatf("%s st_addr[%0d]", name, k), st_addr_q[k], k);
    chk({name, " start_pulses"}, start_cnt - s0, 1);
    chk({name, " cycles"}, cycles, lat);
  endtask

  task automatic run_job(input string name, input int ins, input int qbit, input int lat,
                         input bit gappy, input bit stall, input bit fix_amp);
    int s0;
    prep(ins, qbit, fix_amp);
    mock_lat = lat;
    s0 = start_cnt;
    send_cmd(ins, qbit);
    if (ins > 0) begin
      chk({name, " ctx_ready_first"}, host.o_ctx_ready, 1);
      chk({name, " st_ready_idle"}, host.o_st_ready, 0);
    end else begin
      chk({name, " st_ready_first"}, host.o_st_ready, 1);
    end
    chk({name, " qbit_out"}, qbit_out, qbit);
    chk({name, " busy"}, busy, 1);
    load_ctx(name, gappy);
    load_st(name, gappy);
    read_out(name, stall);
    post_check(name, lat, s0);
  endtask

  task automatic err_cmd(input string name, input int qbit);
    int s0 = strobe_cnt;
    send_cmd(5, qbit);
    chk({name, " err_pulse"}, err, 1);
    chk({name, " busy"}, busy, 0);
    chk({name, " cmd_ready"}, host.o_cmd_ready, 1);
    chk({name, " ctx_ready"}, host.o_ctx_ready, 0);
    @(negedge clk);
    chk({name, " err_clear"}, err, 0);
    chk({name, " no_strobes"}, strobe_cnt - s0, 0);
  endtask

  initial begin
    host.i_cmd_valid = 1'b0; host.i_cmd_ins_num = '0; host.i_cmd_qbit_num = '0;
    host.i_ctx_valid = 1'b0; host.i_ctx_data = '0;
    host.i_st_valid  = 1'b0; host.i_st_data  = '0;
    host.i_rd_ready  = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst cmd_ready", host.o_cmd_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done_err", {done, err}, 0);
    chk("rst cycles", cycles, 0);
    chk("rst qea_ctrl", {start, qbit_out, ctx_en, ctx_wea, st_ena, st_wea}, 0);
    chk("rst qea_addr", {ctx_addr, st_addra}, 0);
    chk("rst qea_data", ctx_data, 0);
    chk("rst qea_dina", st_dina, 0);
    chk("rst readies", {host.o_ctx_ready, host.o_st_ready}, 0);
    chk("rst rd", {host.o_rd_valid, host.o_rd_last}, 0);
    chk("rst rd_data", host.o_rd_data, 0);

    run_job("job87", 87, 3, 50, 1'b0, 1'b0, 1'b1);
    // complete is still high from job87 while the next START cycle runs
    chk("stale complete high", qea_complete, 1);
    run_job("gapped", int'($urandom_range(1, 40)), 4, int'($urandom_range(5, 60)), 1'b1, 1'b1, 1'b0);

    err_cmd("q1", 1);
    err_cmd("q0", 0);
    err_cmd("q19", 19);

    run_job("noctx", 0, 2, 1, 1'b0, 1'b0, 1'b0);

    prep(6, 3, 1'b0);
    mock_lat = 40;
    send_cmd(6, 3);
    load_ctx("abort", 1'b0);
    load_st("abort", 1'b0);
    repeat (8) @(negedge clk);
    chk("abort busy_run", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort strobes", {start, st_ena, ctx_en, host.o_rd_valid}, 0);
    chk("abort cycles", cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort cmd_ready", host.o_cmd_ready, 1);
    run_job("post_abort", 0, 5, int'($urandom_range(2, 30)), 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++)
      run_job($sformatf("rnd%0d", r), int'($urandom_range(0, 20)), int'($urandom_range(2, 5)),
              int'($urandom_range(1, 30)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/qea_host_ctrl.md
# qea_host_ctrl

Hardware sequencer that drives one QEA instance through a full job: stream gate-context words into the context RAM, stream the initial state vector into the state RAM, pulse start, wait for completion while counting cycles, then stream the final state vector back out. It sits between a host-side stream interface (DMA/bus bridge) and the QEA load/start/readout ports. It replaces bench-driven loading so jobs run back-to-back on silicon.

## Interface
Parameters:
- PE_NUM, 4, amplitudes per state RAM word
- DATA_WIDTH, 32, real/imag component width; amplitude = 2*DATA_WIDTH
- MAX_QBIT_WIDTH, 6, width of qubit-count fields
- STATE_ADDR_WIDTH, 16, state RAM address width
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
- RD_LAT, 1, QEA state RAM read latency in cycles (1..4)
- CYC_WIDTH, 32, execution cycle counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_cmd_valid / o_cmd_ready  in/out  1  job command handshake
- i_cmd_ins_num  in  GATE_CONTEXT_ADDR_WIDTH+1  context words to load (0 = keep current context)
- i_cmd_qbit_num  in  MAX_QBIT_WIDTH  qubit count for the job
- i_ctx_valid / o_ctx_ready / i_ctx_data  in/out/in  1/1/2*DATA_WIDTH  context word stream
- i_st_valid / o_st_ready / i_st_data  in/out/in  1/1/PE_NUM*2*DATA_WIDTH  initial state stream
- o_rd_valid / i_rd_ready / o_rd_data / o_rd_last  out/in/out/out  1/1/PE_NUM*2*DATA_WIDTH/1  result stream
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle pulse after last result word accepted
- o_err  out  1  one-cycle pulse on rejected command
- o_cycles  out  CYC_WIDTH  execution cycles of last job (start pulse to complete seen)
- o_qea_start, o_qea_qbit_num  out  1/MAX_QBIT_WIDTH  to QEA i_start / i_qbit_num
- o_qea_ctx_en, o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data  out  QEA context port
- o_qea_state_ena, o_qea_state_wea, o_qea_state_addra, o_qea_state_dina  out  QEA state port
- i_qea_complete  in  1  QEA o_complete
- i_qea_state_dout  in  PE_NUM*2*DATA_WIDTH  QEA o_state_dout

## Operation
- States: IDLE, LD_CTX, LD_ST, START, RUN, RD_ADDR, RD_WAIT, RD_OUT.
- IDLE: o_cmd_ready=1. On handshake latch ins_num, qbit_num; N_ST = 2**(qbit_num-2). qbit_num<2 or N_ST > 2**STATE_ADDR_WIDTH -> o_err pulse, stay IDLE. Else -> LD_CTX (ins_num>0) or LD_ST.
- LD_CTX: o_ctx_ready=1; each accepted word drives ctx_en=wea=1, addr=k (k from 0), data=word, same cycle as handshake (combinational from handshake, addr/data from counter/input registers issued next cycle is not allowed). After word ins_num-1 -> LD_ST.
- LD_ST: o_st_ready=1; each accepted word drives state_ena=wea=1, addra=k, dina=word. After N_ST words -> START.
- START: o_qea_start=1 exactly one cycle; cycle counter cleared to 1 -> RUN.
- RUN: counter increments each cycle; i_qea_complete sampled only in RUN (stale complete during START ignored). On complete=1 latch counter into o_cycles -> RD_ADDR. Counter saturates at all-ones.
- RD_ADDR: ena=1, wea=0, addra=j -> RD_WAIT; wait RD_LAT cycles, capture i_qea_state_dout into output register -> RD_OUT.
- RD_OUT: o_rd_valid=1, o_rd_last=(j==N_ST-1); holds data until i_rd_ready. On accept: last -> o_done pulse, IDLE; else j+1 -> RD_ADDR.
- o_qea_qbit_num driven from latched value continuously; all other QEA strobes 0 outside their states.
- o_busy=1 in every state except IDLE.

## Timing
- Reset: state IDLE; all counters 0; o_cmd_ready=1 after reset release; o_cycles=0; every other output 0.
- Reset mid-job aborts immediately; no partial strobes after rst_n low.
- Load throughput: one word/cycle when valid held high; backpressure by valid only (ready never drops within LD_CTX/LD_ST).
- Readout: one word per RD_LAT+2 cycles at best.
- Command latency: first ctx/state ready asserted the cycle after cmd handshake.
- Stream inputs ignored (ready=0) outside their states.

## Test plan
- Reset: rst_n low then high -> all outputs 0 except o_cmd_ready=1, o_busy=0.
- 3-qubit job, ins_num=87, 2 state words (first word amplitude 0 = 64'h40000000_00000000): ctx addr 0..86 written in order, state addr 0..1, single-cycle start, 2 result words, o_rd_last on second, o_done pulse.
- Complete held high from prior job during START -> not taken; o_cycles equals true start-to-complete distance (mock QEA with 50-cycle latency -> o_cycles=50).
- Gapped valid on ctx stream and i_rd_ready low for 5 cycles -> no dropped/duplicated words, o_rd_data stable while stalled.
- Command with qbit_num=1 -> o_err pulse, no QEA strobes, stays IDLE; ins_num=0 -> no ctx writes, proceeds to LD_ST.
- rst_n asserted in RUN -> IDLE next cycle, o_qea_start/ena 0, new job then completes normally.
